// File: rtl/dmem_pkg.sv
// Shared constants for the byte-serial data memory arbiter.
// State encoding, word geometry and requester port indices.
package dmem_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int CPU = 0;
    localparam int DBG = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a last-grant pointer.
// The pointer moves only when en is high and a grant is issued.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        if (req[CPU] && req[DBG]) begin
            if (last_q == 1'b1) gnt[CPU] = 1'b1;
            else                gnt[DBG] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    always_comb begin
        last_d = last_q;
        if (en && gnt[DBG])      last_d = 1'b1;
        else if (en && gnt[CPU]) last_d = 1'b0;
    end

    // Reset value says DBG went last, so CPU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/debug word access to a byte memory, 4 big-endian beats.
// Optional DMEM_ARB_ALIGN_CHECK_EN adds err and rejects misaligned words.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              cpu_gnt,
    output logic              dbg_gnt,
    output logic              cpu_done,
    output logic              dbg_done,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    output logic              err,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_WORD - 1);

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic              mis_q, mis_d;
`endif

    logic       idle;
    logic [1:0] a_req;
    logic [1:0] a_gnt;
    logic [1:0] lane;
    logic [ADDR_W-1:0] sel_addr;

    assign idle  = (state_q == ST_IDLE);
    assign a_req = {dbg_req, cpu_req} & {2{idle}};
    assign lane  = LAST_BEAT - beat_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (a_req),
        .en    (idle),
        .gnt   (a_gnt)
    );

    // Grants are combinational, so mask them while reset is held.
    assign cpu_gnt  = rst_n & a_gnt[CPU];
    assign dbg_gnt  = rst_n & a_gnt[DBG];
    assign rdata    = rdata_q;
    assign sel_addr = a_gnt[DBG] ? dbg_addr : cpu_addr;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        rdata_d   = rdata_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_done  = 1'b0;
        dbg_done  = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        mis_d     = mis_q;
        err       = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|a_gnt) begin
                    owner_d = a_gnt[DBG];
                    we_d    = a_gnt[DBG] ? dbg_we : cpu_we;
                    addr_d  = sel_addr;
                    wdata_d = a_gnt[DBG] ? dbg_wdata : cpu_wdata;
                    beat_d  = 2'd0;
                    state_d = ST_BEAT;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                    mis_d   = |sel_addr[1:0];
                    if (|sel_addr[1:0]) state_d = ST_DONE;
`endif
                end
            end
            ST_BEAT: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q + ADDR_W'(beat_q);
                mem_wdata = wdata_q[{lane, 3'b000} +: 8];
                beat_d    = beat_q + 2'd1;
                if (!we_q) rbuf_d[{lane, 3'b000} +: 8] = mem_rdata;
                // rdata changes only when the whole word has arrived.
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_DONE;
                    beat_d  = 2'd0;
                    if (!we_q) rdata_d = rbuf_d;
                end
            end
            ST_DONE: begin
                cpu_done = (owner_q == 1'(CPU));
                dbg_done = (owner_q == 1'(DBG));
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                err      = mis_q;
`endif
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers queue expected events,
// a negedge monitor pops and compares grants, beats and completions.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [4:0]  cpu_addr, dbg_addr, mem_addr;
    logic [31:0] cpu_wdata, dbg_wdata, rdata;
    logic        cpu_gnt, dbg_gnt, cpu_done, dbg_done;
    logic        mem_en, mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic        err;
`endif

    logic [7:0] mem [32] = '{default: 8'h00};
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int g_cyc = 0;
    logic [31:0] exp_last_rd = '0;

    typedef struct {
        int          kind;
        logic        port;
        logic        we;
        logic [4:0]  addr;
        logic [7:0]  b;
        int          k;
        logic [31:0] rd;
    } ev_t;

    ev_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .cpu_gnt   (cpu_gnt),
        .dbg_gnt   (dbg_gnt),
        .cpu_done  (cpu_done),
        .dbg_done  (dbg_done),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        .err       (err),
`endif
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_acc(input logic port, input logic we,
                            input logic [4:0] a, input logic [31:0] wd,
                            input logic [31:0] rd);
        ev_t e;
        if (!we) exp_last_rd = rd;
        e.port = port; e.we = we; e.rd = exp_last_rd;
        e.kind = 0; e.addr = a; e.b = 8'h00; e.k = 0;
        q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            e.kind = 1;
            e.k    = k;
            e.addr = a + 5'(k);
            e.b    = 8'(wd >> (24 - 8 * k));
            q.push_back(e);
        end
        e.kind = 2;
        q.push_back(e);
    endtask

    task automatic pop_ev(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        if (q.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            ok = (kind == e.kind);
        end
    endtask

    // Monitor: every grant, beat and done must match the queue head.
    initial begin
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cpu_gnt || dbg_gnt) begin
                    chk("gnt_onehot", 32'(cpu_gnt & dbg_gnt), 32'd0);
                    pop_ev(0, e, ok);
                    if (ok) chk("gnt_port", 32'(dbg_gnt), 32'(e.port));
                    g_cyc = cyc;
                end
                if (mem_en) begin
                    pop_ev(1, e, ok);
                    if (ok) begin
                        chk("beat_cycle", 32'(cyc - g_cyc), 32'(e.k + 1));
                        chk("beat_addr", 32'(mem_addr), 32'(e.addr));
                        chk("beat_we", 32'(mem_we), 32'(e.we));
                        if (e.we) chk("beat_wdata", 32'(mem_wdata), 32'(e.b));
                    end
                end
                if (cpu_done || dbg_done) begin
                    chk("done_onehot", 32'(cpu_done & dbg_done), 32'd0);
                    pop_ev(2, e, ok);
                    if (ok) begin
                        chk("done_cycle", 32'(cyc - g_cyc), 32'd5);
                        chk("done_port", 32'(dbg_done), 32'(e.port));
                        chk("done_rdata", rdata, e.rd);
                    end
                end
            end
        end
    end

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [4:0] a, input logic [31:0] wd);
        if (port) begin
            dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
    endtask

    task automatic access(input logic port, input logic we,
                          input logic [4:0] a, input logic [31:0] wd,
                          input logic [31:0] rd);
        bit seen;
        push_acc(port, we, a, wd, rd);
        @(posedge clk); #1;
        drive(port, 1'b1, we, a, wd);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = port ? dbg_gnt : cpu_gnt;
        end
        if (!seen) chk("gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, 5'd0, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = port ? dbg_done : cpu_done;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_last_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit seen;
        int gc [4];
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #12;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", 32'({cpu_done, dbg_done}), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 1'b1, 5'h04, 32'h1122_3344, 32'd0);
        chk("mem4_7", {mem[4], mem[5], mem[6], mem[7]}, 32'h1122_3344);
        access(1'b1, 1'b0, 5'h04, 32'd0, 32'h1122_3344);
        access(1'b0, 1'b1, 5'h1E, 32'hAABB_CCDD, 32'd0);
        chk("wrap_bytes", {mem[30], mem[31], mem[0], mem[1]},
            32'hAABB_CCDD);
        access(1'b1, 1'b1, 5'h10, 32'hCAFE_F00D, 32'd0);
        access(1'b0, 1'b0, 5'h1E, 32'd0, 32'hAABB_CCDD);

        // Both ports requesting from reset: CPU, DBG, CPU, DBG.
        do_reset();
        push_acc(1'b0, 1'b0, 5'h04, 32'd0, 32'h1122_3344);
        push_acc(1'b1, 1'b0, 5'h1E, 32'd0, 32'hAABB_CCDD);
        push_acc(1'b0, 1'b0, 5'h04, 32'd0, 32'h1122_3344);
        push_acc(1'b1, 1'b0, 5'h1E, 32'd0, 32'hAABB_CCDD);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 5'h04, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 5'h1E, 32'd0);
        for (int g = 0; g < 4; g++) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = cpu_gnt | dbg_gnt;
            end
            if (!seen) chk("rr_gnt_timeout", 32'd0, 32'd1);
            gc[g] = cyc;
            if (g > 0) chk("rr_spacing", 32'(gc[g] - gc[g-1]), 32'd6);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (8) @(negedge clk);

        // Reset during beat 2 of a write to 0x08.
        push_acc(1'b0, 1'b1, 5'h08, 32'hDEAD_BEEF, 32'd0);
        repeat (3) void'(q.pop_back());
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 5'h08, 32'hDEAD_BEEF);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = cpu_gnt;
        end
        if (!seen) chk("abort_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_last_rd = '0;
        #1;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({cpu_done, dbg_done}), 32'd0);
        end
        rst_n = 1'b1;
        chk("abort_bytes", {mem[8], mem[9], mem[10], mem[11]},
            32'hDEAD_0000);
        access(1'b0, 1'b0, 5'h08, 32'd0, 32'hDEAD_0000);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
